// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the two-client memory bus: request-tag field codes,
// line/beat geometry and the line-reader state type. Masters and the arbiter
// import this package so every client encodes tags identically.
//
// Request tag layout (13 bits): {rw[12], kind[11:8], client_tag[7:0]}
// -----------------------------------------------------------------------------
package bus_pkg;

  // Tag field codes
  localparam logic       TAG_READ    = 1'b1;
  localparam logic       TAG_WRITE   = 1'b0;
  localparam logic [3:0] TYPE_MEMORY = 4'b0001;
  localparam logic [3:0] TYPE_MMIO   = 4'b0010;

  // Geometry: 64-byte lines carried over a 64-bit bus
  localparam int LINE_BYTES = 64;
  localparam int BEAT_BITS  = 64;
  localparam int LINE_BITS  = LINE_BYTES * 8;
  localparam int BEATS      = LINE_BITS / BEAT_BITS;
  localparam int CNT_W      = $clog2(BEATS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic [12:0] make_reqtag(input logic       rw,
                                              input logic [3:0] kind,
                                              input logic [7:0] tag);
    return {rw, kind, tag};
  endfunction

endpackage

// File: rtl/bus_line_reader.sv
// -----------------------------------------------------------------------------
// bus_line_reader
// Single-outstanding cache-line read master for one client port of the shared
// memory bus. Accepts a line-fill request, bids for the bus, issues one read,
// gathers the 8-beat response into a 512-bit line and returns it to the cache
// over a valid/ready handshake.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   in_valid/in_ready   line-fill request handshake (ready only while idle)
//   in_addr[63:0]       byte address of the request, any alignment
//   out_valid/out_ready line return handshake
//   out_addr[63:0]      line-aligned address of the returned line
//   out_line[511:0]     returned line, beat k at [64k+63:64k]
//   bus_bid             request for bus ownership (held through the response)
//   bus_reqcyc          read request valid, held until bus_reqack
//   bus_req[63:0]       line-aligned read address
//   bus_reqtag[12:0]    {READ, MEMORY, TAG}
//   bus_reqack          request accepted by the bus
//   bus_respcyc         response beat valid
//   bus_resp[63:0]      response beat data
//   bus_respack         beat acknowledge, same cycle as bus_respcyc
// -----------------------------------------------------------------------------
module bus_line_reader
  import bus_pkg::*;
#(
  parameter logic [7:0] TAG = 8'h00
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [63:0]  in_addr,
  output logic         in_ready,
  output logic         out_valid,
  output logic [63:0]  out_addr,
  output logic [511:0] out_line,
  input  logic         out_ready,
  output logic         bus_bid,
  output logic         bus_reqcyc,
  output logic [63:0]  bus_req,
  output logic [12:0]  bus_reqtag,
  output logic         bus_respack,
  input  logic         bus_reqack,
  input  logic         bus_respcyc,
  input  logic [63:0]  bus_resp
);

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 bid_q;
  logic                 reqcyc_q;
  logic                 out_valid_q;
  logic [63:0]          addr_q;
  logic [12:0]          reqtag_q;
  logic [LINE_BITS-1:0] line_q;
  logic [LINE_BITS-1:0] line_d;

  logic [63:0]          line_addr;
  logic                 beat_we;
  logic                 last_beat;

  // Masking keeps every address bit in use while dropping the byte offset.
  assign line_addr = in_addr & ~64'(LINE_BYTES - 1);

  // Beats are only taken in RESP; a respcyc anywhere else (including the
  // reqack cycle) is neither stored nor acknowledged.
  assign beat_we   = (state_q == ST_RESP) && bus_respcyc;
  assign last_beat = beat_we && (cnt_q == CNT_W'(BEATS - 1));

  assign in_ready    = (state_q == ST_IDLE);
  assign bus_respack = beat_we;

  // Beat-indexed write enable into the line register.
  always_comb begin
    line_d = line_q;
    for (int k = 0; k < BEATS; k++) begin
      if (beat_we && (cnt_q == CNT_W'(k))) begin
        line_d[k*BEAT_BITS +: BEAT_BITS] = bus_resp;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Abandons any transaction in flight: dropping bid releases the arbiter
      // and partially gathered beats are discarded.
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bid_q       <= 1'b0;
      reqcyc_q    <= 1'b0;
      out_valid_q <= 1'b0;
      addr_q      <= '0;
      reqtag_q    <= '0;
      line_q      <= '0;
    end else begin
      line_q <= line_d;
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            addr_q   <= line_addr;
            reqtag_q <= make_reqtag(TAG_READ, TYPE_MEMORY, TAG);
            bid_q    <= 1'b1;
            reqcyc_q <= 1'b1;
            cnt_q    <= '0;
            state_q  <= ST_REQ;
          end
        end
        ST_REQ: begin
          // bid stays up through the response so the arbiter keeps the
          // response path pointed at this client.
          if (bus_reqack) begin
            reqcyc_q <= 1'b0;
            state_q  <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (beat_we) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_beat) begin
              bid_q       <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign out_addr   = addr_q;
  assign out_line   = line_q;
  assign bus_bid    = bid_q;
  assign bus_reqcyc = reqcyc_q;
  assign bus_req    = addr_q;
  assign bus_reqtag = reqtag_q;

endmodule

// File: tb/tb_bus_line_reader.sv
// Testbench for bus_line_reader: two instances (TAG 0 and 1) share a
// behavioural bus slave that serves one client at a time, client 0 first.
module tb_bus_line_reader;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         in_valid  [2];
  logic [63:0]  in_addr   [2];
  logic         in_ready  [2];
  logic         out_valid [2];
  logic [63:0]  out_addr  [2];
  logic [511:0] out_line  [2];
  logic         out_ready [2];
  logic         bid       [2];
  logic         reqcyc    [2];
  logic [63:0]  req       [2];
  logic [12:0]  reqtag    [2];
  logic         respack   [2];
  logic         s_reqack  [2];
  logic         s_respcyc [2];
  logic [63:0]  s_resp    [2];
  logic         st_respcyc[2];
  logic [63:0]  st_resp   [2];
  logic         respcyc   [2];
  logic [63:0]  resp      [2];

  assign respcyc[0] = s_respcyc[0] | st_respcyc[0];
  assign respcyc[1] = s_respcyc[1] | st_respcyc[1];
  assign resp[0]    = st_respcyc[0] ? st_resp[0] : s_resp[0];
  assign resp[1]    = st_respcyc[1] ? st_resp[1] : s_resp[1];

  bus_line_reader #(.TAG(8'h00)) u0 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[0]), .in_addr(in_addr[0]), .in_ready(in_ready[0]),
    .out_valid(out_valid[0]), .out_addr(out_addr[0]), .out_line(out_line[0]),
    .out_ready(out_ready[0]),
    .bus_bid(bid[0]), .bus_reqcyc(reqcyc[0]), .bus_req(req[0]),
    .bus_reqtag(reqtag[0]), .bus_respack(respack[0]),
    .bus_reqack(s_reqack[0]), .bus_respcyc(respcyc[0]), .bus_resp(resp[0])
  );

  bus_line_reader #(.TAG(8'h01)) u1 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[1]), .in_addr(in_addr[1]), .in_ready(in_ready[1]),
    .out_valid(out_valid[1]), .out_addr(out_addr[1]), .out_line(out_line[1]),
    .out_ready(out_ready[1]),
    .bus_bid(bid[1]), .bus_reqcyc(reqcyc[1]), .bus_req(req[1]),
    .bus_reqtag(reqtag[1]), .bus_respack(respack[1]),
    .bus_reqack(s_reqack[1]), .bus_respcyc(respcyc[1]), .bus_resp(resp[1])
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Slave configuration and record of what it sent
  int          ack_dly   = 0;
  int          gap       = 0;
  bit          rand_data = 0;
  bit          abort     = 0;
  logic [63:0] sent    [2][8];
  logic [63:0] cap_req [2];
  logic [12:0] cap_tag [2];

  // Monitor counters
  int reqcyc_n[2];
  int respack_n[2];
  int respack_bad[2];
  int last_beat_cyc[2];
  int viol_n = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (reqcyc[i] === 1'b1) reqcyc_n[i]++;
      if (respack[i] === 1'b1) begin
        respack_n[i]++;
        last_beat_cyc[i] = cyc;
        if (respcyc[i] !== 1'b1) respack_bad[i]++;
      end
      if (s_reqack[i] === 1'b1 && respcyc[i] === 1'b1) viol_n++;
    end
  end

  task automatic sstep();
    @(posedge clk);
    #2;
    if (reset === 1'b1) abort = 1;
  endtask

  // Behavioural memory: one transaction at a time, client 0 has priority.
  initial begin : slave
    int c;
    for (int i = 0; i < 2; i++) begin
      s_reqack[i] = 0; s_respcyc[i] = 0; s_resp[i] = '0;
    end
    forever begin
      sstep();
      if (reset !== 1'b0) continue;
      if (bid[0] === 1'b1 && reqcyc[0] === 1'b1) c = 0;
      else if (bid[1] === 1'b1 && reqcyc[1] === 1'b1) c = 1;
      else continue;
      abort = 0;
      cap_req[c] = req[c];
      cap_tag[c] = reqtag[c];
      for (int i = 0; i < ack_dly; i++) sstep();
      s_reqack[c] = 1;
      sstep();
      s_reqack[c] = 0;
      for (int k = 0; k < 8 && !abort; k++) begin
        sent[c][k]   = rand_data ? {$urandom, $urandom} : 64'h100 + 64'(k);
        s_resp[c]    = sent[c][k];
        s_respcyc[c] = 1;
        sstep();
        s_respcyc[c] = 0;
        for (int g = 0; g < gap && !abort; g++) sstep();
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
    $fatal(1);
  end

  // Reference model
  function automatic logic [511:0] model_line(input int c);
    logic [511:0] l;
    for (int k = 0; k < 8; k++) l[k*64 +: 64] = sent[c][k];
    return l;
  endfunction

  function automatic logic [63:0] model_addr(input logic [63:0] a);
    return a & ~64'h3F;
  endfunction

  function automatic int model_latency(input int ad, input int gp);
    return 1 + (ad + 1) + 8 + 7 * gp;
  endfunction

  // Stimulus helpers
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    for (int i = 0; i < 2; i++) begin
      reqcyc_n[i] = 0; respack_n[i] = 0; respack_bad[i] = 0; last_beat_cyc[i] = -1;
    end
  endtask

  task automatic issue(input int c, input logic [63:0] a, output int t);
    bit got = 0;
    t = -1;
    cycle();
    in_valid[c] = 1;
    in_addr[c]  = a;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (in_ready[c] === 1'b1) begin got = 1; t = cyc; end
      else cycle();
    end
    cycle();
    in_valid[c] = 0;
  endtask

  task automatic wait_ov(input int c, output int t);
    t = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (out_valid[c] === 1'b1) begin t = cyc; break; end
    end
  endtask

  task automatic consume(input int c);
    cycle();
    out_ready[c] = 1;
    cycle();
    out_ready[c] = 0;
  endtask

  // Tests
  task automatic test_reset();
    reset = 1;
    cycle(); cycle();
    @(negedge clk);
    n_checks++;
    if ({bid[0], reqcyc[0], respack[0], out_valid[0], in_ready[0]} !== 5'b00001) begin
      n_err++;
      $display("FAIL reset_ctrl: got {bid,reqcyc,respack,out_valid,in_ready}=%b expected 00001",
               {bid[0], reqcyc[0], respack[0], out_valid[0], in_ready[0]});
    end
    n_checks++;
    if (req[0] !== 64'h0 || reqtag[0] !== 13'h0) begin
      n_err++; $display("FAIL reset_req: got req=%h tag=%h expected 0", req[0], reqtag[0]);
    end
    n_checks++;
    if (out_line[0] !== 512'h0 || out_addr[0] !== 64'h0) begin
      n_err++; $display("FAIL reset_data: got addr=%h line=%h expected 0", out_addr[0], out_line[0]);
    end
    cycle();
    reset = 0;
  endtask

  task automatic test_basic_fill();
    int t_acc, t_ov;
    ack_dly = 0; gap = 0; rand_data = 0;
    clear_mon();
    issue(0, 64'h1234_5678, t_acc);
    wait_ov(0, t_ov);
    n_checks++;
    if (t_ov < 0 || t_acc < 0) begin n_err++; $display("FAIL basic_timeout: acc=%0d ov=%0d expected both seen", t_acc, t_ov); end
    n_checks++;
    if (t_ov - t_acc !== 10) begin n_err++; $display("FAIL basic_latency: got %0d expected 10", t_ov - t_acc); end
    n_checks++;
    if (cap_req[0] !== 64'h1234_5640) begin n_err++; $display("FAIL basic_req: got %h expected 0000000012345640", cap_req[0]); end
    n_checks++;
    if (cap_tag[0] !== 13'h1100) begin n_err++; $display("FAIL basic_tag: got %h expected 1100", cap_tag[0]); end
    n_checks++;
    if (out_addr[0] !== 64'h1234_5640) begin n_err++; $display("FAIL basic_addr: got %h expected 0000000012345640", out_addr[0]); end
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (out_line[0][k*64 +: 64] !== 64'h100 + 64'(k)) begin
        n_err++; $display("FAIL basic_beat%0d: got %h expected %h", k, out_line[0][k*64 +: 64], 64'h100 + 64'(k));
      end
    end
    n_checks++;
    if (bid[0] !== 1'b0) begin n_err++; $display("FAIL basic_bid_done: got %b expected 0", bid[0]); end
    consume(0);
    @(negedge clk);
    n_checks++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
      n_err++; $display("FAIL basic_release: got in_ready=%b out_valid=%b expected 1 0", in_ready[0], out_valid[0]);
    end
  endtask

  task automatic test_slow_memory();
    int t_acc, t_ov;
    logic [63:0] a;
    a = {$urandom, $urandom};
    ack_dly = 5; gap = 2; rand_data = 1;
    clear_mon();
    issue(0, a, t_acc);
    wait_ov(0, t_ov);
    n_checks++;
    if (t_ov < 0) begin n_err++; $display("FAIL slow_timeout: out_valid not seen"); end
    n_checks++;
    if (reqcyc_n[0] !== 6) begin n_err++; $display("FAIL slow_reqcyc_len: got %0d expected 6", reqcyc_n[0]); end
    n_checks++;
    if (respack_n[0] !== 8 || respack_bad[0] !== 0) begin
      n_err++; $display("FAIL slow_respack: got %0d pulses (%0d stray) expected 8 (0)", respack_n[0], respack_bad[0]);
    end
    n_checks++;
    if (t_ov !== last_beat_cyc[0] + 1 || bid[0] !== 1'b0) begin
      n_err++; $display("FAIL slow_bid_drop: got ov_cyc=%0d bid=%b expected cyc %0d bid 0", t_ov, bid[0], last_beat_cyc[0] + 1);
    end
    n_checks++;
    if (t_ov - t_acc !== model_latency(5, 2)) begin
      n_err++; $display("FAIL slow_latency: got %0d expected %0d", t_ov - t_acc, model_latency(5, 2));
    end
    n_checks++;
    if (out_line[0] !== model_line(0) || out_addr[0] !== model_addr(a)) begin
      n_err++; $display("FAIL slow_data: got addr=%h expected %h (line differs=%b)", out_addr[0], model_addr(a), out_line[0] !== model_line(0));
    end
    consume(0);
  endtask

  task automatic test_random();
    int t_acc, t_ov, ad, gp;
    logic [63:0] a;
    rand_data = 1;
    for (int it = 0; it < 6; it++) begin
      a  = {$urandom, $urandom};
      ad = $urandom_range(0, 4);
      gp = $urandom_range(0, 2);
      ack_dly = ad; gap = gp;
      clear_mon();
      issue(0, a, t_acc);
      wait_ov(0, t_ov);
      n_checks++;
      if (t_ov - t_acc !== model_latency(ad, gp)) begin
        n_err++; $display("FAIL rand%0d_latency: got %0d expected %0d", it, t_ov - t_acc, model_latency(ad, gp));
      end
      n_checks++;
      if (cap_req[0] !== model_addr(a) || out_addr[0] !== model_addr(a)) begin
        n_err++; $display("FAIL rand%0d_addr: got req=%h out=%h expected %h", it, cap_req[0], out_addr[0], model_addr(a));
      end
      n_checks++;
      if (out_line[0] !== model_line(0)) begin
        n_err++; $display("FAIL rand%0d_line: got %h expected %h", it, out_line[0], model_line(0));
      end
      n_checks++;
      if (respack_n[0] !== 8 || respack_bad[0] !== 0) begin
        n_err++; $display("FAIL rand%0d_respack: got %0d (%0d stray) expected 8 (0)", it, respack_n[0], respack_bad[0]);
      end
      consume(0);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] a1, a2;
    logic [511:0] l1;
    int t_ov, bad;
    a1 = {$urandom, $urandom};
    a2 = {$urandom, $urandom};
    ack_dly = 0; gap = 0; rand_data = 1;
    cycle();
    in_valid[0] = 1; in_addr[0] = a1;
    @(negedge clk);
    n_checks++;
    if (in_ready[0] !== 1'b1) begin n_err++; $display("FAIL bp_first_accept: got in_ready=%b expected 1", in_ready[0]); end
    cycle();
    in_addr[0] = a2;
    wait_ov(0, t_ov);
    l1 = model_line(0);
    n_checks++;
    if (t_ov < 0 || out_line[0] !== l1 || out_addr[0] !== model_addr(a1)) begin
      n_err++; $display("FAIL bp_first_line: got addr=%h expected %h (ov_cyc=%0d)", out_addr[0], model_addr(a1), t_ov);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      @(negedge clk);
      if ({in_ready[0], bid[0], out_valid[0]} !== 3'b001 || out_line[0] !== l1) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_err++; $display("FAIL bp_hold: got %0d bad cycles expected 0", bad); end
    cycle();
    out_ready[0] = 1;
    @(negedge clk);
    n_checks++;
    if (in_ready[0] !== 1'b0) begin n_err++; $display("FAIL bp_ready_during_ack: got %b expected 0", in_ready[0]); end
    cycle();
    out_ready[0] = 0;
    @(negedge clk);
    n_checks++;
    if (in_ready[0] !== 1'b1 || bid[0] !== 1'b0) begin
      n_err++; $display("FAIL bp_second_accept: got in_ready=%b bid=%b expected 1 0", in_ready[0], bid[0]);
    end
    cycle();
    in_valid[0] = 0;
    @(negedge clk);
    n_checks++;
    if (bid[0] !== 1'b1 || req[0] !== model_addr(a2)) begin
      n_err++; $display("FAIL bp_second_req: got bid=%b req=%h expected 1 %h", bid[0], req[0], model_addr(a2));
    end
    wait_ov(0, t_ov);
    n_checks++;
    if (t_ov < 0 || out_line[0] !== model_line(0) || out_addr[0] !== model_addr(a2)) begin
      n_err++; $display("FAIL bp_second_line: got addr=%h expected %h (ov_cyc=%0d)", out_addr[0], model_addr(a2), t_ov);
    end
    consume(0);
  endtask

  task automatic test_stray();
    int t_acc, t_ov;
    logic [511:0] snap;
    ack_dly = 1; gap = 0; rand_data = 1;
    issue(0, {$urandom, $urandom}, t_acc);
    wait_ov(0, t_ov);
    snap = model_line(0);
    cycle();
    st_respcyc[0] = 1; st_resp[0] = 64'hDEAD_BEEF_0BAD_F00D;
    @(negedge clk);
    n_checks++;
    if (respack[0] !== 1'b0) begin n_err++; $display("FAIL stray_done_respack: got %b expected 0", respack[0]); end
    cycle();
    st_respcyc[0] = 0;
    @(negedge clk);
    n_checks++;
    if (out_line[0] !== snap || out_valid[0] !== 1'b1) begin
      n_err++; $display("FAIL stray_done_line: got out_valid=%b line changed=%b expected 1 0", out_valid[0], out_line[0] !== snap);
    end
    consume(0);
    cycle();
    st_respcyc[0] = 1; st_resp[0] = 64'hFFFF_0000_FFFF_0000;
    @(negedge clk);
    n_checks++;
    if (respack[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      n_err++; $display("FAIL stray_idle_respack: got respack=%b in_ready=%b expected 0 1", respack[0], in_ready[0]);
    end
    cycle();
    st_respcyc[0] = 0;
    @(negedge clk);
    n_checks++;
    if (out_line[0] !== snap) begin n_err++; $display("FAIL stray_idle_line: got %h expected %h", out_line[0], snap); end
  endtask

  task automatic test_reset_mid();
    int t_acc, t_ov, nb, bad;
    logic [63:0] b;
    ack_dly = 0; gap = 0; rand_data = 1;
    clear_mon();
    issue(0, {$urandom, $urandom}, t_acc);
    nb = 0;
    for (int i = 0; i < 100 && nb < 4; i++) begin
      @(negedge clk);
      if (respack[0] === 1'b1) nb++;
    end
    n_checks++;
    if (nb !== 4) begin n_err++; $display("FAIL rstmid_beats: got %0d beats expected 4", nb); end
    cycle();
    reset = 1;
    cycle();
    reset = 0;
    @(negedge clk);
    n_checks++;
    if ({bid[0], reqcyc[0], in_ready[0], out_valid[0]} !== 4'b0010) begin
      n_err++; $display("FAIL rstmid_state: got {bid,reqcyc,in_ready,out_valid}=%b expected 0010",
                        {bid[0], reqcyc[0], in_ready[0], out_valid[0]});
    end
    n_checks++;
    if (out_line[0] !== 512'h0) begin n_err++; $display("FAIL rstmid_discard: got %h expected 0", out_line[0]); end
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid[0] !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_err++; $display("FAIL rstmid_no_valid: got %0d cycles with out_valid expected 0", bad); end
    b = {$urandom, $urandom};
    issue(0, b, t_acc);
    wait_ov(0, t_ov);
    n_checks++;
    if (t_ov - t_acc !== model_latency(0, 0) || out_line[0] !== model_line(0) || out_addr[0] !== model_addr(b)) begin
      n_err++; $display("FAIL rstmid_refill: got lat=%0d addr=%h expected %0d %h", t_ov - t_acc, out_addr[0], model_latency(0, 0), model_addr(b));
    end
    consume(0);
  endtask

  task automatic test_two_clients();
    logic [63:0] a0, a1;
    int t0, t1;
    a0 = {$urandom, $urandom};
    a1 = {$urandom, $urandom};
    ack_dly = $urandom_range(0, 2); gap = 0; rand_data = 1;
    clear_mon();
    cycle();
    in_valid[0] = 1; in_addr[0] = a0;
    in_valid[1] = 1; in_addr[1] = a1;
    @(negedge clk);
    n_checks++;
    if (in_ready[0] !== 1'b1 || in_ready[1] !== 1'b1) begin
      n_err++; $display("FAIL two_accept: got ready0=%b ready1=%b expected 1 1", in_ready[0], in_ready[1]);
    end
    cycle();
    in_valid[0] = 0; in_valid[1] = 0;
    t0 = -1; t1 = -1;
    for (int i = 0; i < 400 && (t0 < 0 || t1 < 0); i++) begin
      @(negedge clk);
      if (t0 < 0 && out_valid[0] === 1'b1) t0 = cyc;
      if (t1 < 0 && out_valid[1] === 1'b1) t1 = cyc;
    end
    n_checks++;
    if (t0 < 0 || t1 < 0 || t0 >= t1) begin
      n_err++; $display("FAIL two_order: got done0=%0d done1=%0d expected client 0 first", t0, t1);
    end
    n_checks++;
    if (out_line[0] !== model_line(0) || out_addr[0] !== model_addr(a0)) begin
      n_err++; $display("FAIL two_line0: got addr=%h expected %h (line differs=%b)", out_addr[0], model_addr(a0), out_line[0] !== model_line(0));
    end
    n_checks++;
    if (out_line[1] !== model_line(1) || out_addr[1] !== model_addr(a1)) begin
      n_err++; $display("FAIL two_line1: got addr=%h expected %h (line differs=%b)", out_addr[1], model_addr(a1), out_line[1] !== model_line(1));
    end
    n_checks++;
    if (cap_tag[1] !== 13'h1101 || cap_req[1] !== model_addr(a1)) begin
      n_err++; $display("FAIL two_req1: got tag=%h req=%h expected 1101 %h", cap_tag[1], cap_req[1], model_addr(a1));
    end
    n_checks++;
    if (respack_n[0] !== 8 || respack_n[1] !== 8) begin
      n_err++; $display("FAIL two_respack: got %0d/%0d expected 8/8", respack_n[0], respack_n[1]);
    end
    consume(0);
    consume(1);
  endtask

  initial begin
    reset = 1;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 0; in_addr[i] = '0; out_ready[i] = 0;
      st_respcyc[i] = 0; st_resp[i] = '0;
    end
    clear_mon();
    test_reset();
    test_basic_fill();
    test_slow_memory();
    test_random();
    test_backpressure();
    test_stray();
    test_reset_mid();
    test_two_clients();
    n_checks++;
    if (viol_n !== 0) begin n_err++; $display("FAIL proto_respcyc_with_reqack: got %0d expected 0", viol_n); end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
